sdc_init_sequencer: RTL and testbench
=====================================

// Module: sdc_init_sequencer
// PURPOSE
// - Wishbone master that brings up the SD controller core after reset: programs power control, clock divider,
//   timeout and interrupt enables, then issues CMD0 (and optionally CMD8) and polls for completion.
// - Sits between the system start/status logic and the controller's Wishbone slave port; frees software from bring-up.
// PARAMETERS
// - PWR_VAL      8'd7      value written to power control (0x24)
// - CLK_DIV_VAL  8'd0      value written to clock divider (0x4c); 0 => divide-by-2
// - TMO_VAL      16'hFFFF  value written to timeout register (0x2c)
// - POLL_MAX     1024      max status reads per command before timeout error (>=1)
// PORTS
// - wb_clk_i     in   1   system clock
// - wb_rst_i     in   1   synchronous reset, active-high
// - start_i      in   1   1-cycle pulse; starts sequence when idle, ignored otherwise
// - busy_o       out  1   high from accepted start to DONE/ERR
// - done_o       out  1   sticky success flag, cleared on next accepted start
// - err_o        out  1   sticky failure flag, cleared on next accepted start
// - err_code_o   out  3   1=cmd error bit, 2=poll timeout, 0=none
// - m_wb_cyc_o   out  1   bus cycle
// - m_wb_stb_o   out  1   strobe (equal to cyc)
// - m_wb_we_o    out  1   1=write, 0=read
// - m_wb_adr_o   out  8   byte register address
// - m_wb_dat_o   out  32  write data
// - m_wb_sel_o   out  4   always 4'hF during a cycle
// - m_wb_dat_i   in   32  read data
// - m_wb_ack_i   in   1   slave acknowledge
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, poll counter 0. Reset mid-transfer drops cyc/stb next edge, no completion.
// - Bus: cyc/stb/we/adr/dat/sel registered, held stable until sampled ack=1; drop cyc/stb same edge ack seen;
//   min 1 idle cycle between transfers. ack while cyc=0 ignored. No time-out on missing ack.
// - States/writes in order (all 32-bit, zero-extended):
//   IDLE -> W_PWR(0x24,PWR_VAL) -> W_DIV(0x4c,CLK_DIV_VAL) -> W_TMO(0x2c,TMO_VAL) -> W_NISER(0x38,0x0001)
//   -> W_EISER(0x3c,0x0000) -> CMD0: W_CMD(0x04,0x0000) -> W_ARG(0x00,0x0000) -> POLL -> CLR -> [CMD8] -> DONE
// - POLL: read 0x30 (normal isr). bit15 set => ERR code 1 (bit15 checked before bit0).
//   bit0 set => CLR: write 0x30=0x0 then advance. Neither => counter+1, re-read; counter==POLL_MAX => ERR code 2.
//   Counter cleared on entering each POLL.
// - DONE: done_o=1, busy_o=0, back to IDLE-accepting. ERR: err_o=1, busy_o=0, err_code_o held until next start.
// - start_i while busy ignored; start_i on same cycle as reaching DONE/ERR ignored.
// - Latency (ack after 1 wait, completion on first poll, CMD8 off): fixed per-transfer cost; bench checks order, not count.
// CONFIGURATION
// - SDC_INIT_CMD8_EN defined: after CMD0 CLR, issue CMD8: W_CMD(0x04,0x081A) -> W_ARG(0x00,0x000001AA) -> POLL -> CLR -> DONE.
//   Then read 0x08 (resp0); bits[11:0]!=0x1AA => ERR code 3 (err_code_o encodes 3 only with macro).
// - Not defined: DONE directly after CMD0 CLR; code 3 never produced.
// TESTING
// - Reset, 1-cycle-latency ack slave, start_i -> writes in exact order/addr/data above, sel=F, done_o=1, err_o=0.
// - Slave stretches ack by 0..5 random cycles -> adr/dat/we stable while cyc=1, same write order.
// - isr returns 0 for 3 reads then 0x0001 -> exactly 4 reads of 0x30, then write 0x30=0, done_o=1.
// - isr returns 0x8000 -> err_o=1, err_code_o=1, no further cycles, busy_o=0.
// - isr always 0, POLL_MAX=8 -> exactly 8 reads, err_code_o=2; new start_i clears err_o, re-runs sequence.
// - wb_rst_i asserted while cyc=1 -> cyc/stb 0 next cycle, all flags 0; start_i afterwards restarts at W_PWR.
// - (SDC_INIT_CMD8_EN) resp0=0x1AA -> done; resp0=0x0AA -> err_code_o=3.

Source files
------------

// File: rtl/sdc_init_sequencer.sv
// -----------------------------------------------------------------------------
// sdc_init_sequencer
//
// Wishbone master that brings the SD controller core up after reset. On an
// accepted start pulse it programs power control, clock divider, timeout and
// interrupt enables, issues CMD0, and polls the normal interrupt status
// register until the command completes, errors, or the poll budget runs out.
//
// Optional feature (macro SDC_INIT_CMD8_EN): after CMD0 also issues CMD8,
// polls it, then reads resp0 and checks the echoed check pattern (0x1AA).
//
// Ports
//   wb_clk_i     system clock
//   wb_rst_i     synchronous reset, active-high
//   start_i      1-cycle start pulse, honoured only while idle
//   busy_o       sequence in progress
//   done_o       sticky success flag, cleared by next accepted start
//   err_o        sticky failure flag, cleared by next accepted start
//   err_code_o   1 = command error, 2 = poll timeout, 3 = bad CMD8 response
//   m_wb_*       Wishbone classic master port (stb mirrors cyc, sel = 4'hF)
// -----------------------------------------------------------------------------
module sdc_init_sequencer #(
    parameter logic [7:0]  PWR_VAL     = 8'd7,
    parameter logic [7:0]  CLK_DIV_VAL = 8'd0,
    parameter logic [15:0] TMO_VAL     = 16'hFFFF,
    parameter int unsigned POLL_MAX    = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_we_o,
    output logic [7:0]  m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic [3:0]  m_wb_sel_o,
    input  logic [31:0] m_wb_dat_i,
    input  logic        m_wb_ack_i
);

    localparam int unsigned CntW      = $clog2(POLL_MAX + 1);
    localparam logic [CntW:0] PollLimit = POLL_MAX[CntW:0];
    localparam logic [2:0]  ErrCmd    = 3'd1;
    localparam logic [2:0]  ErrTmo    = 3'd2;
`ifdef SDC_INIT_CMD8_EN
    localparam logic [2:0]  ErrResp   = 3'd3;
`endif

    typedef enum logic [3:0] {
        StIdle, StWPwr, StWDiv, StWTmo, StWNiser, StWEiser,
        StWCmd, StWArg, StPoll, StClr, StRdResp
    } state_e;

    state_e            r_state, w_state_d;
    logic              r_cyc, w_cyc_d;
    logic              r_we, w_we_d;
    logic [7:0]        r_adr, w_adr_d;
    logic [31:0]       r_dat, w_dat_d;
    logic [3:0]        r_sel, w_sel_d;
    logic              r_done, w_done_d;
    logic              r_err, w_err_d;
    logic [2:0]        r_code, w_code_d;
    logic [CntW-1:0]   r_poll_cnt, w_poll_cnt_d;
    logic [CntW:0]     w_cnt_inc;
`ifdef SDC_INIT_CMD8_EN
    logic              r_cmd8, w_cmd8_d;
`endif

    // Transfer issued by the current state
    logic              w_xfer_we;
    logic [7:0]        w_xfer_adr;
    logic [31:0]       w_xfer_dat;
    logic              w_unused_dat;

    assign w_unused_dat = ^m_wb_dat_i;
    assign w_cnt_inc    = {1'b0, r_poll_cnt} + {{CntW{1'b0}}, 1'b1};

    always_comb begin
        w_xfer_we  = 1'b1;
        w_xfer_adr = 8'h00;
        w_xfer_dat = 32'h0;
        case (r_state)
            StWPwr:   begin w_xfer_adr = 8'h24; w_xfer_dat = {24'h0, PWR_VAL};     end
            StWDiv:   begin w_xfer_adr = 8'h4c; w_xfer_dat = {24'h0, CLK_DIV_VAL}; end
            StWTmo:   begin w_xfer_adr = 8'h2c; w_xfer_dat = {16'h0, TMO_VAL};     end
            StWNiser: begin w_xfer_adr = 8'h38; w_xfer_dat = 32'h0000_0001;        end
            StWEiser: begin w_xfer_adr = 8'h3c; w_xfer_dat = 32'h0;                end
            StWCmd: begin
                w_xfer_adr = 8'h04;
`ifdef SDC_INIT_CMD8_EN
                w_xfer_dat = r_cmd8 ? 32'h0000_081A : 32'h0;
`endif
            end
            StWArg: begin
                w_xfer_adr = 8'h00;
`ifdef SDC_INIT_CMD8_EN
                w_xfer_dat = r_cmd8 ? 32'h0000_01AA : 32'h0;
`endif
            end
            StPoll:   begin w_xfer_we = 1'b0; w_xfer_adr = 8'h30; end
            StClr:    begin w_xfer_adr = 8'h30; end
            StRdResp: begin w_xfer_we = 1'b0; w_xfer_adr = 8'h08; end
            default:  ;
        endcase
    end

    always_comb begin
        w_state_d    = r_state;
        w_cyc_d      = r_cyc;
        w_we_d       = r_we;
        w_adr_d      = r_adr;
        w_dat_d      = r_dat;
        w_sel_d      = r_sel;
        w_done_d     = r_done;
        w_err_d      = r_err;
        w_code_d     = r_code;
        w_poll_cnt_d = r_poll_cnt;
`ifdef SDC_INIT_CMD8_EN
        w_cmd8_d     = r_cmd8;
`endif

        if (r_state == StIdle) begin
            if (start_i) begin
                w_state_d    = StWPwr;
                w_done_d     = 1'b0;
                w_err_d      = 1'b0;
                w_code_d     = 3'd0;
                w_poll_cnt_d = '0;
`ifdef SDC_INIT_CMD8_EN
                w_cmd8_d     = 1'b0;
`endif
            end
        end else if (!r_cyc) begin
            // A cycle with cyc low always precedes a launch, giving the idle gap
            w_cyc_d = 1'b1;
            w_we_d  = w_xfer_we;
            w_adr_d = w_xfer_adr;
            w_dat_d = w_xfer_dat;
            w_sel_d = 4'hF;
        end else if (m_wb_ack_i) begin
            w_cyc_d = 1'b0;
            w_sel_d = 4'h0;
            case (r_state)
                StWPwr:   w_state_d = StWDiv;
                StWDiv:   w_state_d = StWTmo;
                StWTmo:   w_state_d = StWNiser;
                StWNiser: w_state_d = StWEiser;
                StWEiser: w_state_d = StWCmd;
                StWCmd:   w_state_d = StWArg;
                StWArg: begin
                    w_state_d    = StPoll;
                    w_poll_cnt_d = '0;
                end
                StPoll: begin
                    // Error bit wins over completion bit
                    if (m_wb_dat_i[15]) begin
                        w_state_d = StIdle;
                        w_err_d   = 1'b1;
                        w_code_d  = ErrCmd;
                    end else if (m_wb_dat_i[0]) begin
                        w_state_d = StClr;
                    end else if (w_cnt_inc == PollLimit) begin
                        w_state_d = StIdle;
                        w_err_d   = 1'b1;
                        w_code_d  = ErrTmo;
                    end else begin
                        w_poll_cnt_d = w_cnt_inc[CntW-1:0];
                    end
                end
                StClr: begin
`ifdef SDC_INIT_CMD8_EN
                    if (!r_cmd8) begin
                        w_cmd8_d  = 1'b1;
                        w_state_d = StWCmd;
                    end else begin
                        w_state_d = StRdResp;
                    end
`else
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
`endif
                end
`ifdef SDC_INIT_CMD8_EN
                StRdResp: begin
                    w_state_d = StIdle;
                    if (m_wb_dat_i[11:0] != 12'h1AA) begin
                        w_err_d  = 1'b1;
                        w_code_d = ErrResp;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
`endif
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= StIdle;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= 8'h00;
            r_dat      <= 32'h0;
            r_sel      <= 4'h0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= 3'd0;
            r_poll_cnt <= '0;
`ifdef SDC_INIT_CMD8_EN
            r_cmd8     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cyc      <= w_cyc_d;
            r_we       <= w_we_d;
            r_adr      <= w_adr_d;
            r_dat      <= w_dat_d;
            r_sel      <= w_sel_d;
            r_done     <= w_done_d;
            r_err      <= w_err_d;
            r_code     <= w_code_d;
            r_poll_cnt <= w_poll_cnt_d;
`ifdef SDC_INIT_CMD8_EN
            r_cmd8     <= w_cmd8_d;
`endif
        end
    end

    assign busy_o     = (r_state != StIdle);
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign err_code_o = r_code;
    assign m_wb_cyc_o = r_cyc;
    assign m_wb_stb_o = r_cyc;
    assign m_wb_we_o  = r_we;
    assign m_wb_adr_o = r_adr;
    assign m_wb_dat_o = r_dat;
    assign m_wb_sel_o = r_sel;

endmodule

// File: tb/tb_sdc_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdc_init_sequencer
//
// Drives sdc_init_sequencer against a Wishbone slave model with configurable
// ack stretch and a scripted interrupt status sequence. Expected transfer lists
// and outcomes come from a transaction-level model of the bring-up sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdc_init_sequencer;

    localparam int unsigned PollMax = 8;
    localparam logic [7:0]  PwrVal  = 8'd7;
    localparam logic [7:0]  DivVal  = 8'd0;
    localparam logic [15:0] TmoVal  = 16'hFFFF;
`ifdef SDC_INIT_CMD8_EN
    localparam int NCmd = 2;
`else
    localparam int NCmd = 1;
`endif

    typedef struct packed {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [2:0]  code;
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat_o;
    logic [3:0]  sel;
    logic [31:0] sdat;
    logic        ack;

    always #5 clk = ~clk;

    sdc_init_sequencer #(
        .PWR_VAL     (PwrVal),
        .CLK_DIV_VAL (DivVal),
        .TMO_VAL     (TmoVal),
        .POLL_MAX    (PollMax)
    ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_code_o (code),
        .m_wb_cyc_o (cyc),
        .m_wb_stb_o (stb),
        .m_wb_we_o  (we),
        .m_wb_adr_o (adr),
        .m_wb_dat_o (dat_o),
        .m_wb_sel_o (sel),
        .m_wb_dat_i (sdat),
        .m_wb_ack_i (ack)
    );

    xfer_t       log_q[$];
    xfer_t       exp_q[$];
    logic [31:0] isr_q[$];
    logic [31:0] scr_q[$];
    logic [31:0] resp0 = 32'h0000_01AA;
    int          stretch_lo = 0;
    int          stretch_hi = 0;
    int          stab_err = 0;
    int          stb_err = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          exp_code;
    bit          exp_done;

    // Slave: captures each cycle, optionally stretches ack, checks the request
    // stays stable while waiting, and logs completed transfers.
    initial begin
        xfer_t cap;
        int    n;
        bit    aborted;
        ack  = 1'b0;
        sdat = 32'h0;
        forever begin
            @(posedge clk); #1;
            ack = 1'b0;
            if (cyc === 1'b1 && rst === 1'b0) begin
                cap.we  = we;
                cap.adr = adr;
                cap.dat = we ? dat_o : 32'h0;
                cap.sel = sel;
                n = $urandom_range(stretch_hi, stretch_lo);
                aborted = 1'b0;
                for (int i = 0; i < n; i++) begin
                    @(posedge clk); #1;
                    if (cyc !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (we !== cap.we || adr !== cap.adr || sel !== cap.sel ||
                        (cap.we && dat_o !== cap.dat)) stab_err++;
                end
                if (!aborted && rst === 1'b0) begin
                    if (!cap.we && cap.adr == 8'h30)
                        sdat = (isr_q.size() > 0) ? isr_q.pop_front() : 32'h0;
                    else if (!cap.we && cap.adr == 8'h08)
                        sdat = resp0;
                    else
                        sdat = 32'h0;
                    ack = 1'b1;
                    log_q.push_back(cap);
                end
            end
        end
    end

    always @(negedge clk) if (stb !== cyc) stb_err++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic void exp_push(input logic w, input logic [7:0] a, input logic [31:0] d);
        xfer_t t;
        t.we  = w;
        t.adr = a;
        t.dat = w ? d : 32'h0;
        t.sel = 4'hF;
        exp_q.push_back(t);
    endfunction

    // Transaction-level model of the bring-up sequence for the current script
    task automatic model_build();
        logic [31:0] s[$];
        logic [31:0] v;
        int          polls;
        s = scr_q;
        exp_q.delete();
        exp_code = 0;
        exp_done = 1'b0;
        exp_push(1'b1, 8'h24, {24'h0, PwrVal});
        exp_push(1'b1, 8'h4c, {24'h0, DivVal});
        exp_push(1'b1, 8'h2c, {16'h0, TmoVal});
        exp_push(1'b1, 8'h38, 32'h1);
        exp_push(1'b1, 8'h3c, 32'h0);
        for (int c = 0; c < NCmd; c++) begin
            exp_push(1'b1, 8'h04, (c == 0) ? 32'h0 : 32'h081A);
            exp_push(1'b1, 8'h00, (c == 0) ? 32'h0 : 32'h01AA);
            polls = 0;
            forever begin
                exp_push(1'b0, 8'h30, 32'h0);
                v = (s.size() > 0) ? s.pop_front() : 32'h0;
                polls++;
                if (v[15]) begin exp_code = 1; return; end
                if (v[0]) break;
                if (polls == PollMax) begin exp_code = 2; return; end
            end
            exp_push(1'b1, 8'h30, 32'h0);
        end
        if (NCmd == 2) begin
            exp_push(1'b0, 8'h08, 32'h0);
            if (resp0[11:0] != 12'h1AA) begin exp_code = 3; return; end
        end
        exp_done = 1'b1;
    endtask

    function automatic int first_diff();
        int m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) if (log_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int poll_reads();
        int k = 0;
        foreach (log_q[i]) begin
            if (log_q[i].adr == 8'h30 && log_q[i].we) break;
            if (log_q[i].adr == 8'h30) k++;
        end
        return k;
    endfunction

    task automatic prep();
        isr_q = scr_q;
        log_q.delete();
        stab_err = 0;
        stb_err = 0;
        model_build();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (busy === 1'b0) begin to = 1'b0; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, err, code} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {busy, done, err, code});
        else n_pass++;
        n_checks++;
        if ({cyc, stb, we, adr, dat_o, sel} !== 47'b0)
            $display("FAIL reset_bus: got %h want 0", {cyc, stb, we, adr, dat_o, sel});
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit to;
        int d;
        stretch_lo = 0; stretch_hi = 0;
        scr_q = '{32'h1, 32'h1};
        prep();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
        wait_idle(to);
        n_checks++;
        if (to) $display("FAIL basic_timeout: busy stuck, want idle"); else n_pass++;
        n_checks++;
        if (log_q.size() != exp_q.size())
            $display("FAIL basic_count: got %0d want %0d", log_q.size(), exp_q.size());
        else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL basic_order: xfer %0d got %h want %h", d, log_q[d], exp_q[d]);
        else n_pass++;
        n_checks++;
        if ({done, err, code} !== 5'b10000)
            $display("FAIL basic_flags: got %b want 10000", {done, err, code});
        else n_pass++;
    endtask

    task automatic test_stretch();
        bit to;
        int d;
        stretch_lo = 0; stretch_hi = 5;
        scr_q = '{32'h1, 32'h1};
        prep();
        pulse_start();
        repeat (3) @(posedge clk);
        pulse_start();  // ignored while busy
        wait_idle(to);
        d = first_diff();
        n_checks++;
        if (to || log_q.size() != exp_q.size() || d >= 0)
            $display("FAIL stretch_order: got %0d xfers (diff at %0d) want %0d",
                     log_q.size(), d, exp_q.size());
        else n_pass++;
        n_checks++;
        if (stab_err != 0 || stb_err != 0)
            $display("FAIL stretch_stable: got %0d/%0d changes want 0", stab_err, stb_err);
        else n_pass++;
        n_checks++;
        if ({done, err} !== 2'b10) $display("FAIL stretch_done: got %b want 10", {done, err});
        else n_pass++;
    endtask

    task automatic test_poll_retry();
        bit to;
        int d;
        stretch_lo = 1; stretch_hi = 1;
        scr_q = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h1};
        prep();
        pulse_start();
        wait_idle(to);
        n_checks++;
        if (poll_reads() != 4) $display("FAIL retry_reads: got %0d want 4", poll_reads());
        else n_pass++;
        d = first_diff();
        n_checks++;
        if (to || log_q.size() != exp_q.size() || d >= 0)
            $display("FAIL retry_order: got %0d xfers (diff at %0d) want %0d",
                     log_q.size(), d, exp_q.size());
        else n_pass++;
        n_checks++;
        if ({done, err} !== 2'b10) $display("FAIL retry_done: got %b want 10", {done, err});
        else n_pass++;
    endtask

    task automatic test_cmd_err();
        bit to;
        int n;
        stretch_lo = 0; stretch_hi = 2;
        scr_q = '{32'h8001};
        prep();
        pulse_start();
        wait_idle(to);
        n = log_q.size();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (to || {done, err, code} !== 5'b01001)
            $display("FAIL cmderr_flags: got %b want 01001", {done, err, code});
        else n_pass++;
        n_checks++;
        if (log_q.size() != n || n != exp_q.size() || cyc !== 1'b0 || busy !== 1'b0)
            $display("FAIL cmderr_quiet: got %0d->%0d xfers cyc %b want %0d quiet",
                     n, log_q.size(), cyc, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_timeout_restart();
        bit to;
        int d;
        stretch_lo = 0; stretch_hi = 1;
        scr_q.delete();
        prep();
        pulse_start();
        wait_idle(to);
        n_checks++;
        if (poll_reads() != PollMax)
            $display("FAIL tmo_reads: got %0d want %0d", poll_reads(), PollMax);
        else n_pass++;
        n_checks++;
        if (to || {done, err, code} !== 5'b01010)
            $display("FAIL tmo_flags: got %b want 01010", {done, err, code});
        else n_pass++;
        scr_q = '{32'h0, 32'h1, 32'h1};
        prep();
        pulse_start();
        n_checks++;
        if ({busy, done, err, code} !== 6'b100000)
            $display("FAIL restart_clear: got %b want 100000", {busy, done, err, code});
        else n_pass++;
        wait_idle(to);
        d = first_diff();
        n_checks++;
        if (to || log_q.size() != exp_q.size() || d >= 0 || done !== 1'b1)
            $display("FAIL restart_run: got %0d xfers done %b want %0d done 1",
                     log_q.size(), done, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit to;
        int d;
        stretch_lo = 5; stretch_hi = 5;
        scr_q = '{32'h1, 32'h1};
        prep();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            if (cyc === 1'b1) break;
            @(posedge clk); #1;
        end
        n_checks++;
        if (cyc !== 1'b1) $display("FAIL rstmid_cyc_up: got %b want 1", cyc); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({cyc, stb, busy, done, err, code} !== 8'b0)
            $display("FAIL rstmid_drop: got %b want 0", {cyc, stb, busy, done, err, code});
        else n_pass++;
        rst = 1'b0;
        n_checks++;
        if (log_q.size() != 0) $display("FAIL rstmid_noack: got %0d want 0", log_q.size());
        else n_pass++;
        stretch_lo = 0; stretch_hi = 2;
        prep();
        pulse_start();
        wait_idle(to);
        d = first_diff();
        n_checks++;
        if (to || log_q.size() != exp_q.size() || d >= 0 || done !== 1'b1)
            $display("FAIL rstmid_rerun: got %0d xfers (diff at %0d) want %0d",
                     log_q.size(), d, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_random();
        bit          to;
        int          d;
        int          len;
        logic [31:0] v;
        for (int it = 0; it < 8; it++) begin
            stretch_lo = 0; stretch_hi = 5;
            scr_q.delete();
            len = $urandom_range(12, 1);
            for (int k = 0; k < len; k++) begin
                v = $urandom();
                case ($urandom_range(3, 0))
                    0, 1:    v = v & 32'hFFFF_7FFE;
                    2:       v = (v & 32'hFFFF_7FFF) | 32'h1;
                    default: v = v | 32'h8000;
                endcase
                scr_q.push_back(v);
            end
            resp0 = $urandom_range(1, 0) ? 32'h0000_01AA : $urandom();
            prep();
            pulse_start();
            wait_idle(to);
            d = first_diff();
            n_checks++;
            if (to || log_q.size() != exp_q.size() || d >= 0)
                $display("FAIL rand%0d_order: got %0d xfers (diff at %0d) want %0d",
                         it, log_q.size(), d, exp_q.size());
            else n_pass++;
            n_checks++;
            if ({done, err, code} !== {exp_done, !exp_done, exp_code[2:0]})
                $display("FAIL rand%0d_flags: got %b want %b", it, {done, err, code},
                         {exp_done, !exp_done, exp_code[2:0]});
            else n_pass++;
            n_checks++;
            if (stab_err != 0 || stb_err != 0)
                $display("FAIL rand%0d_stable: got %0d/%0d want 0", it, stab_err, stb_err);
            else n_pass++;
        end
        resp0 = 32'h0000_01AA;
    endtask

`ifdef SDC_INIT_CMD8_EN
    task automatic test_cmd8();
        bit to;
        int d;
        stretch_lo = 0; stretch_hi = 3;
        for (int r = 0; r < 2; r++) begin
            resp0 = (r == 0) ? 32'h0000_01AA : 32'h0000_00AA;
            scr_q = '{32'h1, 32'h1};
            prep();
            pulse_start();
            wait_idle(to);
            d = first_diff();
            n_checks++;
            if (to || log_q.size() != exp_q.size() || d >= 0)
                $display("FAIL cmd8_%0d_order: got %0d xfers want %0d", r, log_q.size(),
                         exp_q.size());
            else n_pass++;
            n_checks++;
            if ({done, err, code} !== ((r == 0) ? 5'b10000 : 5'b01011))
                $display("FAIL cmd8_%0d_flags: got %b want %b", r, {done, err, code},
                         (r == 0) ? 5'b10000 : 5'b01011);
            else n_pass++;
        end
        resp0 = 32'h0000_01AA;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stretch();
        test_poll_retry();
        test_cmd_err();
        test_timeout_restart();
        test_reset_mid();
        test_random();
`ifdef SDC_INIT_CMD8_EN
        test_cmd8();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
